// File: rtl/dq_fill_ctrl_pkg.sv
// Shared parameters, derived widths and state type for the decode-queue fill controller.
package dq_fill_ctrl_pkg;

    localparam int DQ_N       = 8;
    localparam int MQ_N       = 4;
    localparam int REFILL_LAT = 2;

    // Width of a count that must hold 0..n inclusive
    function automatic int occ_width(input int n);
        return $clog2(n) + 1;
    endfunction

    function automatic int cnt_width(input int n);
        return $clog2(n) + 1;
    endfunction

    localparam int OCC_W = occ_width(DQ_N);
    localparam int CNT_W = cnt_width(MQ_N);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_FLUSH  = 2'd1,
        ST_REFILL = 2'd2
    } dq_state_e;

endpackage

// File: rtl/dq_fill_ctrl_if.sv
// Fetch/decode handshake bundle between the fetch side (master) and the fill controller (slave).
interface dq_fill_if #(
    parameter int DQ_N = dq_fill_ctrl_pkg::DQ_N,
    parameter int MQ_N = dq_fill_ctrl_pkg::MQ_N
);
    import dq_fill_ctrl_pkg::*;

    localparam int OW = occ_width(DQ_N);
    localparam int CW = cnt_width(MQ_N);

    logic          fet_ready;
    logic [CW-1:0] fet_count;
    logic          dec_ready;
    logic          redirect;
    logic          fet_valid;
    logic          fet_accept;
    logic          dq_stall;
    logic          dq_flush;
    logic [OW-1:0] occ;
    logic          dq_empty;
    logic          dq_full;

    modport master (
        output fet_ready, fet_count, dec_ready, redirect,
        input  fet_valid, fet_accept, dq_stall, dq_flush, occ, dq_empty, dq_full
    );

    modport slave (
        input  fet_ready, fet_count, dec_ready, redirect,
        output fet_valid, fet_accept, dq_stall, dq_flush, occ, dq_empty, dq_full
    );

endinterface

// File: rtl/dq_fill_ctrl_refill_timer.sv
// Refill-latency down-counter: load on flush, decrement while refilling, flag at zero.
module dq_refill_timer #(
    parameter int TW = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [TW-1:0] load_val,
    input  logic          dec,
    output logic          zero
);

    logic [TW-1:0] cnt_q;
    logic [TW-1:0] cnt_d;

    // Next count: load wins over decrement; never decrement below zero
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != {TW{1'b0}})) begin
            cnt_d = cnt_q - {{(TW-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= {TW{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == {TW{1'b0}});

endmodule

// File: rtl/dq_fill_ctrl.sv
// Decode-queue fill controller: gates whole fetch bundles into the queue by free space
// and sequences flush/refill after a redirect or reset.
module dq_fill_ctrl #(
    parameter int DQ_N       = dq_fill_ctrl_pkg::DQ_N,
    parameter int MQ_N       = dq_fill_ctrl_pkg::MQ_N,
    parameter int REFILL_LAT = dq_fill_ctrl_pkg::REFILL_LAT
) (
    input logic      clk,
    input logic      rst,
    dq_fill_if.slave dq_bus
);
    import dq_fill_ctrl_pkg::*;

    localparam int OW  = occ_width(DQ_N);
    localparam int CW  = cnt_width(MQ_N);
    localparam int SW  = ((OW > CW) ? OW : CW) + 1;
    localparam int TW  = (REFILL_LAT > 1) ? $clog2(REFILL_LAT) : 1;
    localparam int LDV = (REFILL_LAT > 0) ? (REFILL_LAT - 1) : 0;

    dq_state_e     state_q;
    dq_state_e     state_d;
    dq_state_e     state_nr_s;
    logic [OW-1:0] occ_q;
    logic [OW-1:0] occ_d;
    logic [OW-1:0] occ_nr_s;
    logic [SW-1:0] fill_sum_s;
    logic          pop_s;
    logic          fet_valid_s;
    logic          fet_accept_s;
    logic          dq_stall_s;
    logic          dq_flush_s;
    logic          tmr_load_s;
    logic          tmr_dec_s;
    logic          tmr_zero_s;

    dq_refill_timer #(.TW(TW)) u_refill_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load_s),
        .load_val (TW'(LDV)),
        .dec      (tmr_dec_s),
        .zero     (tmr_zero_s)
    );

    // Next-state, occupancy and handshake outputs
    always_comb begin
        state_nr_s   = state_q;
        occ_nr_s     = occ_q;
        fill_sum_s   = {SW{1'b0}};
        pop_s        = 1'b0;
        fet_valid_s  = 1'b0;
        fet_accept_s = 1'b0;
        dq_stall_s   = 1'b0;
        dq_flush_s   = 1'b0;
        tmr_load_s   = 1'b0;
        tmr_dec_s    = 1'b0;

        case (state_q)
            ST_RUN: begin
                dq_stall_s = ~dq_bus.dec_ready;
                pop_s      = ~dq_stall_s & (occ_q != {OW{1'b0}});
                // Widened so occ - pop + count can be compared against DQ_N without wrapping
                fill_sum_s = SW'(occ_q) - SW'(pop_s) + SW'(dq_bus.fet_count);
                if (dq_bus.fet_ready && !dq_stall_s && !dq_bus.redirect &&
                    (dq_bus.fet_count != {CW{1'b0}}) && (fill_sum_s <= SW'(DQ_N))) begin
                    fet_valid_s = 1'b1;
                end else begin
                    fet_valid_s = 1'b0;
                end
                if (fet_valid_s) begin
                    fet_accept_s = 1'b1;
                    occ_nr_s     = OW'(fill_sum_s);
                end else if (dq_bus.fet_ready && !dq_stall_s && !dq_bus.redirect &&
                             (dq_bus.fet_count == {CW{1'b0}})) begin
                    fet_accept_s = 1'b1;
                    occ_nr_s     = occ_q - OW'(pop_s);
                end else begin
                    fet_accept_s = 1'b0;
                    occ_nr_s     = occ_q - OW'(pop_s);
                end
            end
            ST_FLUSH: begin
                dq_flush_s   = 1'b1;
                fet_accept_s = 1'b1;
                occ_nr_s     = {OW{1'b0}};
                if (REFILL_LAT == 32'sd0) begin
                    state_nr_s = ST_RUN;
                end else begin
                    state_nr_s = ST_REFILL;
                    tmr_load_s = 1'b1;
                end
            end
            ST_REFILL: begin
                fet_accept_s = 1'b1;
                dq_stall_s   = 1'b1;
                occ_nr_s     = {OW{1'b0}};
                if (tmr_zero_s) begin
                    state_nr_s = ST_RUN;
                end else begin
                    tmr_dec_s  = 1'b1;
                end
            end
            default: begin
                state_nr_s = ST_FLUSH;
                occ_nr_s   = {OW{1'b0}};
            end
        endcase

        if (dq_bus.redirect) begin
            state_d = ST_FLUSH;
            occ_d   = {OW{1'b0}};
        end else begin
            state_d = state_nr_s;
            occ_d   = occ_nr_s;
        end
    end

    // State and occupancy registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_FLUSH;
            occ_q   <= {OW{1'b0}};
        end else begin
            state_q <= state_d;
            occ_q   <= occ_d;
        end
    end

    assign dq_bus.fet_valid  = fet_valid_s;
    assign dq_bus.fet_accept = fet_accept_s;
    assign dq_bus.dq_stall   = dq_stall_s;
    assign dq_bus.dq_flush   = dq_flush_s;
    assign dq_bus.occ        = occ_q;
    assign dq_bus.dq_empty   = (occ_q == {OW{1'b0}});
    assign dq_bus.dq_full    = (occ_q == OW'(DQ_N));

endmodule

// File: tb/tb_dq_fill_ctrl.sv
// Randomised and directed bench for dq_fill_ctrl against a cycles-since-flush reference model.
module tb_dq_fill_ctrl;

    localparam int DQ_N = 8;
    localparam int MQ_N = 4;
    localparam int RL   = 2;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    dq_fill_if #(.DQ_N(DQ_N), .MQ_N(MQ_N)) dq_bus ();

    dq_fill_ctrl #(.DQ_N(DQ_N), .MQ_N(MQ_N), .REFILL_LAT(RL)) u_dut (
        .clk    (clk),
        .rst    (rst),
        .dq_bus (dq_bus.slave)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Model: occupancy = entries written minus entries popped since the last flush;
    // mode follows from how many cycles have passed since the flush cycle.
    int m_occ   = 0;
    int m_since = 0;
    bit m_known = 1'b0;
    int e_valid, e_accept, e_stall, e_flush, e_pop, e_cnt;

    task automatic check_eq(input string tag, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic drive(input bit r, input bit rdy, input int cnt, input bit dec, input bit redir);
        rst              = r;
        dq_bus.fet_ready = rdy;
        dq_bus.fet_count = cnt[$bits(dq_bus.fet_count)-1:0];
        dq_bus.dec_ready = dec;
        dq_bus.redirect  = redir;
    endtask

    task automatic predict();
        e_cnt    = int'(dq_bus.fet_count);
        e_valid  = 0;
        e_accept = 0;
        e_stall  = 0;
        e_flush  = 0;
        e_pop    = 0;
        if (m_since == 0) begin
            e_flush  = 1;
            e_accept = 1;
        end else if (m_since <= RL) begin
            e_stall  = 1;
            e_accept = 1;
        end else begin
            e_stall = dq_bus.dec_ready ? 0 : 1;
            e_pop   = (e_stall == 0 && m_occ > 0) ? 1 : 0;
            if (!dq_bus.redirect && dq_bus.fet_ready && e_stall == 0) begin
                if (e_cnt == 0)
                    e_accept = 1;
                else if (m_occ - e_pop + e_cnt <= DQ_N) begin
                    e_valid  = 1;
                    e_accept = 1;
                end
            end
        end
    endtask

    task automatic mid();
        #3;
        predict();
    endtask

    task automatic adv();
        if (m_known) begin
            check_eq("fet_valid",  int'(dq_bus.fet_valid),  e_valid);
            check_eq("fet_accept", int'(dq_bus.fet_accept), e_accept);
            check_eq("dq_stall",   int'(dq_bus.dq_stall),   e_stall);
            check_eq("dq_flush",   int'(dq_bus.dq_flush),   e_flush);
            check_eq("occ",        int'(dq_bus.occ),        m_occ);
            check_eq("dq_empty",   int'(dq_bus.dq_empty),   (m_occ == 0) ? 1 : 0);
            check_eq("dq_full",    int'(dq_bus.dq_full),    (m_occ == DQ_N) ? 1 : 0);
            check_eq("occ_bound",  (int'(dq_bus.occ) <= DQ_N) ? 1 : 0, 1);
        end
        if (rst) begin
            m_occ   = 0;
            m_since = 0;
            m_known = 1'b1;
        end else if (dq_bus.redirect) begin
            m_occ   = 0;
            m_since = 0;
        end else if (m_since > RL) begin
            m_occ = m_occ - e_pop + ((e_valid != 0) ? e_cnt : 0);
        end else begin
            m_occ = 0;
            m_since++;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        drive(1'b1, 1'b0, 0, 1'b0, 1'b0);
        mid(); adv();

        // Reset release: one flush cycle, then RL refill cycles with no writes
        drive(1'b0, 1'b1, 4, 1'b1, 1'b0);
        mid();
        check_eq("rst_flush", int'(dq_bus.dq_flush), 1);
        check_eq("rst_occ",   int'(dq_bus.occ), 0);
        check_eq("rst_empty", int'(dq_bus.dq_empty), 1);
        check_eq("rst_fv",    int'(dq_bus.fet_valid), 0);
        adv();
        for (int i = 0; i < RL; i++) begin
            mid();
            check_eq("refill_fv", int'(dq_bus.fet_valid), 0);
            adv();
        end

        // Stalled decoder: no writes
        drive(1'b0, 1'b1, 4, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            mid();
            check_eq("stall_stall", int'(dq_bus.dq_stall), 1);
            check_eq("stall_fv",    int'(dq_bus.fet_valid), 0);
            check_eq("stall_occ",   int'(dq_bus.occ), 0);
            adv();
        end

        // Fill with 4-wide bundles: 0 -> 4 -> 7, then a bundle needing 10 slots is held
        drive(1'b0, 1'b1, 4, 1'b1, 1'b0);
        mid(); check_eq("fill0_occ", int'(dq_bus.occ), 0); check_eq("fill0_fv", int'(dq_bus.fet_valid), 1); adv();
        mid(); check_eq("fill1_occ", int'(dq_bus.occ), 4); check_eq("fill1_fv", int'(dq_bus.fet_valid), 1); adv();
        mid(); check_eq("fill2_occ", int'(dq_bus.occ), 7); check_eq("fill2_fv", int'(dq_bus.fet_valid), 0);
        check_eq("fill2_acc", int'(dq_bus.fet_accept), 0); adv();
        drive(1'b0, 1'b1, 3, 1'b1, 1'b0);
        mid(); check_eq("fill3_occ", int'(dq_bus.occ), 6); check_eq("fill3_fv", int'(dq_bus.fet_valid), 1); adv();

        // Full boundary
        drive(1'b0, 1'b1, 1, 1'b1, 1'b0);
        mid(); check_eq("full_occ", int'(dq_bus.occ), 8); check_eq("full_flag", int'(dq_bus.dq_full), 1);
        check_eq("full_fv1", int'(dq_bus.fet_valid), 1); adv();
        drive(1'b0, 1'b1, 2, 1'b1, 1'b0);
        mid(); check_eq("full_occ2", int'(dq_bus.occ), 8); check_eq("full_fv2", int'(dq_bus.fet_valid), 0);
        check_eq("full_acc2", int'(dq_bus.fet_accept), 0); adv();

        // Empty bundle is dropped, queue still pops
        drive(1'b0, 1'b1, 0, 1'b1, 1'b0);
        mid(); check_eq("nop_occ", int'(dq_bus.occ), 7); check_eq("nop_acc", int'(dq_bus.fet_accept), 1);
        check_eq("nop_fv", int'(dq_bus.fet_valid), 0); adv();

        // Redirect at occ 6 with a writable bundle pending
        drive(1'b0, 1'b1, 1, 1'b1, 1'b1);
        mid(); check_eq("redir_occ", int'(dq_bus.occ), 6); check_eq("redir_fv", int'(dq_bus.fet_valid), 0); adv();
        drive(1'b0, 1'b1, 4, 1'b1, 1'b0);
        mid(); check_eq("redir_flush", int'(dq_bus.dq_flush), 1); check_eq("redir_occ0", int'(dq_bus.occ), 0);
        check_eq("redir_acc", int'(dq_bus.fet_accept), 1); adv();
        drive(1'b0, 1'b1, 4, 1'b1, 1'b1);
        mid(); check_eq("refill_acc", int'(dq_bus.fet_accept), 1); check_eq("refill_fv2", int'(dq_bus.fet_valid), 0); adv();
        drive(1'b0, 1'b1, 4, 1'b1, 1'b0);
        mid(); check_eq("reflush", int'(dq_bus.dq_flush), 1); adv();
        for (int i = 0; i < RL; i++) begin
            mid(); check_eq("refill2_fv", int'(dq_bus.fet_valid), 0); adv();
        end

        // Random traffic against the model
        for (int i = 0; i < 2000; i++) begin
            drive(($urandom_range(0, 199) == 0),
                  ($urandom_range(0, 3) != 0),
                  int'($urandom_range(0, MQ_N)),
                  ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 39) == 0));
            mid();
            adv();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
